// File: rtl/led_blink_array.sv
// Multi-channel LED/heartbeat generator: per-channel programmable period and mode,
// a one-cycle tick on every period wrap, and all channels held idle while the MMCM is unlocked.
module led_blink_array #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CNT_W          = 27,
    parameter int unsigned DEFAULT_PERIOD = 100_000_000,
    parameter int unsigned PULSE_LEN      = 10_000_000
) (
    input  logic                                         clk100,
    input  logic                                         rst,
    input  logic                                         locked,
    input  logic                                         cfg_we,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                             cfg_period,
    input  logic [1:0]                                   cfg_mode,
    output logic [NUM_CH-1:0]                            led,
    output logic [NUM_CH-1:0]                            tick
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_PULSE = 2'd2,
        MODE_ON    = 2'd3
    } mode_e;

    logic [CNT_W-1:0]  r_period [NUM_CH];
    mode_e             r_mode   [NUM_CH];
    logic [CNT_W-1:0]  r_cnt    [NUM_CH];
    logic [NUM_CH-1:0] r_phase;

    logic [CNT_W-1:0]  w_period_nxt [NUM_CH];
    mode_e             w_mode_nxt   [NUM_CH];
    logic [CNT_W-1:0]  w_cnt_nxt    [NUM_CH];
    logic [NUM_CH-1:0] w_phase_nxt;
    logic [NUM_CH-1:0] w_tick_nxt;
    logic [NUM_CH-1:0] w_led_nxt;
    logic [NUM_CH-1:0] w_hit;

    // Next-state per channel: config write beats lock gating, which beats the wrap.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_period_nxt[i] = r_period[i];
            w_mode_nxt[i]   = r_mode[i];
            w_cnt_nxt[i]    = r_cnt[i] + CNT_W'(1);
            w_phase_nxt[i]  = r_phase[i];
            w_tick_nxt[i]   = 1'b0;
            w_led_nxt[i]    = 1'b0;
            w_hit[i]        = cfg_we && (cfg_ch == CH_W'(i));

            if (w_hit[i]) begin
                w_period_nxt[i] = cfg_period;
                w_mode_nxt[i]   = mode_e'(cfg_mode);
                w_cnt_nxt[i]    = '0;
                w_phase_nxt[i]  = 1'b0;
            end else if (!locked) begin
                w_cnt_nxt[i]    = '0;
                w_phase_nxt[i]  = 1'b0;
            end else if (r_cnt[i] == r_period[i]) begin
                w_cnt_nxt[i]    = '0;
                w_phase_nxt[i]  = ~r_phase[i];
                w_tick_nxt[i]   = 1'b1;
            end

            // LED follows the post-edge counter/phase; dark while unlocked.
            if (locked) begin
                case (w_mode_nxt[i])
                    MODE_OFF:   w_led_nxt[i] = 1'b0;
                    MODE_BLINK: w_led_nxt[i] = w_phase_nxt[i];
                    MODE_PULSE: w_led_nxt[i] = (64'(w_cnt_nxt[i]) < 64'(PULSE_LEN));
                    MODE_ON:    w_led_nxt[i] = 1'b1;
                    default:    w_led_nxt[i] = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_period[i] <= CNT_W'(DEFAULT_PERIOD);
                r_mode[i]   <= MODE_BLINK;
                r_cnt[i]    <= '0;
            end
            r_phase <= '0;
            led     <= '0;
            tick    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_period[i] <= w_period_nxt[i];
                r_mode[i]   <= w_mode_nxt[i];
                r_cnt[i]    <= w_cnt_nxt[i];
            end
            r_phase <= w_phase_nxt;
            led     <= w_led_nxt;
            tick    <= w_tick_nxt;
        end
    end

endmodule

// File: tb/tb_led_blink_array.sv
// Bench for led_blink_array: directed scenarios plus random config/lock traffic,
// checked against an elapsed-cycle arithmetic model of each channel.
module tb_led_blink_array;

    localparam int unsigned NCH   = 4;
    localparam int unsigned CW    = 8;
    localparam int unsigned DEF_P = 9;
    localparam int unsigned PLEN  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          locked = 1'b1;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_ch = '0;
    logic [CW-1:0] cfg_period = '0;
    logic [1:0]    cfg_mode = '0;
    logic [NCH-1:0] led, tick;
    logic [2:0]     led_b, tick_b;

    always #5 clk = ~clk;

    led_blink_array #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_PERIOD(DEF_P), .PULSE_LEN(PLEN)) u_dut (
        .clk100(clk), .rst(rst), .locked(locked), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_mode(cfg_mode), .led(led), .tick(tick)
    );

    // Three-channel copy: cfg_ch=3 is out of range here and must be ignored.
    led_blink_array #(.NUM_CH(3), .CNT_W(CW), .DEFAULT_PERIOD(DEF_P), .PULSE_LEN(PLEN)) u_dut3 (
        .clk100(clk), .rst(rst), .locked(locked), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_mode(cfg_mode), .led(led_b), .tick(tick_b)
    );

    // Model: period, mode and counting edges elapsed since the last restart.
    int m_p [NCH];
    int m_m [NCH];
    int m_e [NCH];
    logic [NCH-1:0] exp_led, exp_tick;
    int n_vec = 0;
    int n_err = 0;

    function automatic logic led_fn(input int mode, input int c, input int ph);
        case (mode)
            0: return 1'b0;
            1: return ph[0];
            2: return (c < int'(PLEN));
            default: return 1'b1;
        endcase
    endfunction

    function automatic int cur_cnt(input int i);
        return m_e[i] % (m_p[i] + 1);
    endfunction

    task automatic model_edge();
        int c, ph;
        for (int i = 0; i < int'(NCH); i++) begin
            if (rst) begin
                m_p[i] = int'(DEF_P); m_m[i] = 1; m_e[i] = 0;
                exp_led[i] = 1'b0; exp_tick[i] = 1'b0;
            end else if (cfg_we && int'(cfg_ch) == i) begin
                m_p[i] = int'(cfg_period); m_m[i] = int'(cfg_mode); m_e[i] = 0;
                exp_tick[i] = 1'b0;
                exp_led[i]  = locked ? led_fn(m_m[i], 0, 0) : 1'b0;
            end else if (!locked) begin
                m_e[i] = 0; exp_tick[i] = 1'b0; exp_led[i] = 1'b0;
            end else begin
                m_e[i] = m_e[i] + 1;
                c  = m_e[i] % (m_p[i] + 1);
                ph = (m_e[i] / (m_p[i] + 1)) % 2;
                exp_tick[i] = (c == 0);
                exp_led[i]  = led_fn(m_m[i], c, ph);
            end
        end
    endtask

    task automatic step(input string tag);
        logic [2:0] el3, et3;
        @(posedge clk);
        model_edge();
        #1;
        el3 = exp_led[2:0];
        et3 = exp_tick[2:0];
        n_vec++;
        assert (led === exp_led) else begin
            n_err++; $error("FAIL %s led observed=%b expected=%b", tag, led, exp_led);
        end
        assert (tick === exp_tick) else begin
            n_err++; $error("FAIL %s tick observed=%b expected=%b", tag, tick, exp_tick);
        end
        assert (led_b === el3) else begin
            n_err++; $error("FAIL %s led3 observed=%b expected=%b", tag, led_b, el3);
        end
        assert (tick_b === et3) else begin
            n_err++; $error("FAIL %s tick3 observed=%b expected=%b", tag, tick_b, et3);
        end
    endtask

    task automatic write(input int ch, input int per, input int mode, input string tag);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_period = CW'(per); cfg_mode = 2'(mode);
        step(tag);
        cfg_we = 1'b0;
    endtask

    initial begin
        int guard;
        for (int i = 0; i < int'(NCH); i++) begin
            m_p[i] = int'(DEF_P); m_m[i] = 1; m_e[i] = 0;
        end
        exp_led = '0; exp_tick = '0;

        // Reset, then free-run at the default period.
        step("reset0");
        step("reset1");
        rst = 1'b0;
        for (int k = 0; k < 42; k++) step("default_run");

        // Channel 1 pulse mode with short period.
        write(1, 3, 2, "wr_ch1_pulse");
        for (int k = 0; k < 12; k++) step("ch1_pulse");

        // Drop lock when ch0 sits at cnt 5.
        guard = 0;
        while (cur_cnt(0) != 5 && guard < 20) begin step("seek_cnt5"); guard++; end
        assert (guard < 20) else begin
            n_err++; $error("FAIL seek_cnt5 observed=timeout expected=cnt5");
        end
        locked = 1'b0;
        for (int k = 0; k < 7; k++) step("unlocked");
        locked = 1'b1;
        for (int k = 0; k < 22; k++) step("relock");

        // Channel 2 at period 0: tick every cycle.
        write(2, 0, 1, "wr_ch2_p0");
        for (int k = 0; k < 6; k++) step("ch2_p0");

        // Write ch0 exactly on its wrap cycle.
        guard = 0;
        while (cur_cnt(0) != m_p[0] && guard < 20) begin step("seek_wrap"); guard++; end
        assert (guard < 20) else begin
            n_err++; $error("FAIL seek_wrap observed=timeout expected=wrap");
        end
        write(0, 5, 1, "wr_on_wrap");
        for (int k = 0; k < 14; k++) step("after_wrap_wr");

        // ch3 write: real on 4-ch DUT, out of range on 3-ch DUT.
        write(3, 4, 3, "wr_ch3_on");
        for (int k = 0; k < 7; k++) step("ch3_on");

        // Config write while unlocked, then relock.
        locked = 1'b0;
        write(1, 6, 3, "wr_unlocked");
        step("unlocked2");
        locked = 1'b1;
        for (int k = 0; k < 10; k++) step("relock2");

        // Random traffic.
        for (int k = 0; k < 500; k++) begin
            cfg_we     = ($urandom_range(0, 6) == 0);
            cfg_ch     = 2'($urandom_range(0, 3));
            cfg_period = CW'($urandom_range(0, 12));
            cfg_mode   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) locked = ~locked;
            rst = ($urandom_range(0, 149) == 0);
            step("random");
            rst = 1'b0;
        end
        cfg_we = 1'b0;
        locked = 1'b1;

        // Reset mid-count with ch3 ON.
        write(3, 7, 3, "wr_ch3_on2");
        for (int k = 0; k < 5; k++) step("pre_rst");
        rst = 1'b1;
        step("mid_rst");
        rst = 1'b0;
        for (int k = 0; k < 24; k++) step("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
